// File: rtl/fifo_write_ctrl_if.sv
// ----------------------------------------------------------------------------
// fifo_write_ctrl_if
// Purpose : bundles the write-side handshake and status signals of the FIFO
//           write controller.
// Signals : INC          write request from the transmitting device
//           R_PTR        read pointer from the read-side controller
//           CLR_OVF      synchronous clear of OVERFLOW / DROP_CNT
//           W_PTR        registered write pointer (MSB = wrap bit)
//           ADDR_OUT     memory write address
//           WEN          memory write strobe
//           FULL_FLAG    FIFO full
//           ALMOST_FULL  occupancy at or above threshold
//           COUNT        current occupancy
//           OVERFLOW     sticky rejected-write flag
//           DROP_CNT     saturating count of rejected writes
// Modports: master drives requests and observes status; slave is the
//           write controller.
// ----------------------------------------------------------------------------
interface fifo_write_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             INC;
   logic [WIDTH-1:0] R_PTR;
   logic             CLR_OVF;
   logic [WIDTH-1:0] W_PTR;
   logic [WIDTH-2:0] ADDR_OUT;
   logic             WEN;
   logic             FULL_FLAG;
   logic             ALMOST_FULL;
   logic [WIDTH-1:0] COUNT;
   logic             OVERFLOW;
   logic [7:0]       DROP_CNT;

   modport master (
      output INC, R_PTR, CLR_OVF,
      input  W_PTR, ADDR_OUT, WEN, FULL_FLAG, ALMOST_FULL, COUNT, OVERFLOW, DROP_CNT
   );

   modport slave (
      input  INC, R_PTR, CLR_OVF,
      output W_PTR, ADDR_OUT, WEN, FULL_FLAG, ALMOST_FULL, COUNT, OVERFLOW, DROP_CNT
   );
endinterface

// File: rtl/fifo_write_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_write_ctrl
// Purpose : write-side pointer and flag logic of a synchronous FIFO. Keeps a
//           WIDTH-bit write pointer whose MSB is a wrap bit, derives occupancy,
//           full and almost-full from it and the read pointer, and tracks
//           writes that were rejected because the FIFO was full.
// Ports   : CLK  rising-edge clock
//           RST  asynchronous active-low reset
//           bus  fifo_write_ctrl_if.slave (see interface header)
// Params  : WIDTH      pointer width; DEPTH = 2**(WIDTH-1)
//           AF_THRESH  occupancy at or above which ALMOST_FULL asserts (1..DEPTH)
// ----------------------------------------------------------------------------
module fifo_write_ctrl #(
   parameter int WIDTH     = 8,
   parameter int AF_THRESH = (2 ** (WIDTH - 1)) - 4
) (
   input  logic               CLK,
   input  logic               RST,
   fifo_write_ctrl_if.slave   bus
);

   localparam logic [WIDTH-1:0] AF_THRESH_C = WIDTH'(AF_THRESH);
   localparam logic [WIDTH-1:0] PTR_ONE_C   = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] w_ptr_r;
   logic [WIDTH-1:0] w_ptr_nxt_s;
   logic [WIDTH-1:0] count_s;
   logic             full_s;
   logic             accept_s;
   logic             reject_s;
   logic             overflow_r;
   logic             overflow_nxt_s;
   logic [7:0]       drop_cnt_r;
   logic [7:0]       drop_cnt_nxt_s;

   // Occupancy, full detection and write acceptance from the current pointers.
   always_comb begin
      count_s  = w_ptr_r - bus.R_PTR;
      // Full: same address, opposite lap. Uses R_PTR as presented this cycle,
      // so a read completing on this edge does not free space until next cycle.
      full_s   = (w_ptr_r[WIDTH-1] != bus.R_PTR[WIDTH-1]) &&
                 (w_ptr_r[WIDTH-2:0] == bus.R_PTR[WIDTH-2:0]);
      // The strobe is held low during reset so no stray write reaches memory.
      accept_s = bus.INC & ~full_s & RST;
      reject_s = bus.INC & full_s;
   end

   // Next-state values for the pointer and the overflow bookkeeping.
   always_comb begin
      w_ptr_nxt_s    = w_ptr_r;
      overflow_nxt_s = overflow_r;
      drop_cnt_nxt_s = drop_cnt_r;

      if (accept_s) begin
         w_ptr_nxt_s = w_ptr_r + PTR_ONE_C;
      end else begin
         w_ptr_nxt_s = w_ptr_r;
      end

      // Clear wins over a rejection landing in the same cycle.
      if (bus.CLR_OVF) begin
         overflow_nxt_s = 1'b0;
         drop_cnt_nxt_s = 8'd0;
      end else if (reject_s) begin
         overflow_nxt_s = 1'b1;
         if (drop_cnt_r != 8'hFF) begin
            drop_cnt_nxt_s = drop_cnt_r + 8'd1;
         end else begin
            drop_cnt_nxt_s = drop_cnt_r;
         end
      end else begin
         overflow_nxt_s = overflow_r;
         drop_cnt_nxt_s = drop_cnt_r;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         w_ptr_r    <= {WIDTH{1'b0}};
         overflow_r <= 1'b0;
         drop_cnt_r <= 8'd0;
      end else begin
         w_ptr_r    <= w_ptr_nxt_s;
         overflow_r <= overflow_nxt_s;
         drop_cnt_r <= drop_cnt_nxt_s;
      end
   end

   // Output mapping.
   assign bus.W_PTR       = w_ptr_r;
   assign bus.ADDR_OUT    = w_ptr_r[WIDTH-2:0];
   assign bus.WEN         = accept_s;
   assign bus.FULL_FLAG   = full_s;
   assign bus.ALMOST_FULL = (count_s >= AF_THRESH_C);
   assign bus.COUNT       = count_s;
   assign bus.OVERFLOW    = overflow_r;
   assign bus.DROP_CNT    = drop_cnt_r;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fifo_write_ctrl
// Purpose : directed self-checking bench for fifo_write_ctrl (WIDTH=8,
//           AF_THRESH=124). Inputs change 1 time unit after the rising edge;
//           outputs are sampled one further unit later.
// ----------------------------------------------------------------------------
module tb_fifo_write_ctrl;

   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   check_cnt = 0;
   int   err_cnt   = 0;

   fifo_write_ctrl_if #(.WIDTH(WIDTH)) bus ();

   fifo_write_ctrl #(.WIDTH(WIDTH), .AF_THRESH(124)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   // 10-unit clock.
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.INC     = 1'b0;
      bus.R_PTR   = 8'h00;
      bus.CLR_OVF = 1'b0;

      // Reset held with the clock running; request must not strobe memory.
      #12;
      bus.INC = 1'b1;
      #1;
      check_eq("rst_wptr",  32'(bus.W_PTR),       32'h00);
      check_eq("rst_addr",  32'(bus.ADDR_OUT),    32'h00);
      check_eq("rst_count", 32'(bus.COUNT),       32'h00);
      check_eq("rst_full",  32'(bus.FULL_FLAG),   32'h0);
      check_eq("rst_af",    32'(bus.ALMOST_FULL), 32'h0);
      check_eq("rst_wen",   32'(bus.WEN),         32'h0);
      check_eq("rst_ovf",   32'(bus.OVERFLOW),    32'h0);
      check_eq("rst_drop",  32'(bus.DROP_CNT),    32'h00);

      // Release reset and fill with R_PTR=0 for 128 cycles.
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 128; i++) begin
         #1;
         if (i == 0) begin
            check_eq("fill_addr0", 32'(bus.ADDR_OUT), 32'h00);
            check_eq("fill_wen0",  32'(bus.WEN),      32'h1);
         end
         if (i == 123) begin
            check_eq("af_cnt123", 32'(bus.COUNT),       32'd123);
            check_eq("af_off123", 32'(bus.ALMOST_FULL), 32'h0);
         end
         if (i == 124) begin
            check_eq("af_cnt124",  32'(bus.COUNT),       32'd124);
            check_eq("af_on124",   32'(bus.ALMOST_FULL), 32'h1);
            check_eq("af_nfull124", 32'(bus.FULL_FLAG),  32'h0);
         end
         if (i == 127) begin
            check_eq("fill_addr127", 32'(bus.ADDR_OUT), 32'h7F);
            check_eq("fill_wen127",  32'(bus.WEN),      32'h1);
         end
         tick();
      end
      #1;
      check_eq("full_wptr",  32'(bus.W_PTR),       32'h80);
      check_eq("full_addr",  32'(bus.ADDR_OUT),    32'h00);
      check_eq("full_count", 32'(bus.COUNT),       32'd128);
      check_eq("full_flag",  32'(bus.FULL_FLAG),   32'h1);
      check_eq("full_af",    32'(bus.ALMOST_FULL), 32'h1);
      check_eq("full_wen",   32'(bus.WEN),         32'h0);

      // Three rejected writes.
      repeat (3) tick();
      check_eq("ovf_wptr", 32'(bus.W_PTR),    32'h80);
      check_eq("ovf_flag", 32'(bus.OVERFLOW), 32'h1);
      check_eq("ovf_drop", 32'(bus.DROP_CNT), 32'd3);

      // Clear coincides with another rejected write: clear wins.
      bus.CLR_OVF = 1'b1;
      tick();
      bus.CLR_OVF = 1'b0;
      bus.INC     = 1'b0;
      #1;
      check_eq("clr_ovf",  32'(bus.OVERFLOW), 32'h0);
      check_eq("clr_drop", 32'(bus.DROP_CNT), 32'd0);

      // Read and write in the same cycle while full.
      bus.INC = 1'b1;
      #1;
      check_eq("rw_full_wen",  32'(bus.WEN),       32'h0);
      check_eq("rw_full_flag", 32'(bus.FULL_FLAG), 32'h1);
      tick();
      bus.R_PTR = 8'h01;
      #1;
      check_eq("rw_after_full",  32'(bus.FULL_FLAG), 32'h0);
      check_eq("rw_after_wen",   32'(bus.WEN),       32'h1);
      check_eq("rw_after_count", 32'(bus.COUNT),     32'd127);
      tick();
      bus.INC = 1'b0;
      #1;
      check_eq("rw_wptr",  32'(bus.W_PTR),     32'h81);
      check_eq("rw_full2", 32'(bus.FULL_FLAG), 32'h1);
      check_eq("rw_count", 32'(bus.COUNT),     32'd128);
      check_eq("rw_drop",  32'(bus.DROP_CNT),  32'd1);

      // Move to W_PTR=0xFF and wrap the pointer MSB.
      bus.R_PTR = 8'h7F;
      bus.INC   = 1'b1;
      repeat (126) tick();
      #1;
      check_eq("pre_wrap_wptr", 32'(bus.W_PTR),     32'hFF);
      check_eq("pre_wrap_full", 32'(bus.FULL_FLAG), 32'h1);
      bus.R_PTR = 8'h80;
      #1;
      check_eq("pre_wrap_count", 32'(bus.COUNT),    32'h7F);
      check_eq("pre_wrap_wen",   32'(bus.WEN),      32'h1);
      check_eq("pre_wrap_addr",  32'(bus.ADDR_OUT), 32'h7F);
      tick();
      bus.INC = 1'b0;
      #1;
      check_eq("wrap_wptr",  32'(bus.W_PTR),     32'h00);
      check_eq("wrap_addr",  32'(bus.ADDR_OUT),  32'h00);
      check_eq("wrap_count", 32'(bus.COUNT),     32'h80);
      check_eq("wrap_full",  32'(bus.FULL_FLAG), 32'h1);

      // 300 rejected writes saturate the drop counter.
      bus.CLR_OVF = 1'b1;
      tick();
      bus.CLR_OVF = 1'b0;
      bus.INC     = 1'b1;
      repeat (300) tick();
      #1;
      check_eq("sat_drop", 32'(bus.DROP_CNT), 32'hFF);
      check_eq("sat_ovf",  32'(bus.OVERFLOW), 32'h1);
      check_eq("sat_wptr", 32'(bus.W_PTR),    32'h00);

      // Free the FIFO, start a burst, then assert reset mid-cycle.
      bus.R_PTR = 8'h00;
      repeat (3) tick();
      check_eq("burst_wptr", 32'(bus.W_PTR), 32'h03);
      #1;
      rst = 1'b0;
      #1;
      check_eq("arst_wptr",  32'(bus.W_PTR),    32'h00);
      check_eq("arst_ovf",   32'(bus.OVERFLOW), 32'h0);
      check_eq("arst_drop",  32'(bus.DROP_CNT), 32'h00);
      check_eq("arst_wen",   32'(bus.WEN),      32'h0);
      check_eq("arst_count", 32'(bus.COUNT),    32'h00);
      repeat (2) tick();
      rst = 1'b1;
      #1;
      check_eq("post_rst_addr", 32'(bus.ADDR_OUT), 32'h00);
      check_eq("post_rst_wen",  32'(bus.WEN),      32'h1);
      tick();
      bus.INC = 1'b0;
      #1;
      check_eq("post_rst_wptr", 32'(bus.W_PTR), 32'h01);

      $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/fifo_write_ctrl.md
FIFO_WRITE_CTRL -- requirements
Module: fifo_write_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pointer width; address width WIDTH-1; DEPTH = 2^(WIDTH-1).
REQ-002 SHALL have parameter AF_THRESH, default DEPTH-4, occupancy at or above which ALMOST_FULL asserts; legal range 1..DEPTH.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port INC  input  1  write request (write enable from transmitting device).
REQ-006 SHALL have port R_PTR  input  WIDTH  read pointer from read-side controller, same clock domain, registered at source.
REQ-007 SHALL have port CLR_OVF  input  1  synchronous clear of OVERFLOW and DROP_CNT.
REQ-008 SHALL have port W_PTR  output  WIDTH  registered write pointer, MSB is wrap bit; goes to read-side empty logic.
REQ-009 SHALL have port ADDR_OUT  output  WIDTH-1  memory write address, equal to W_PTR[WIDTH-2:0].
REQ-010 SHALL have port WEN  output  1  memory write strobe, high for each accepted write.
REQ-011 SHALL have port FULL_FLAG  output  1  high = FIFO full; low = not full.
REQ-012 SHALL have port ALMOST_FULL  output  1  occupancy >= AF_THRESH.
REQ-013 SHALL have port COUNT  output  WIDTH  current occupancy, 0..DEPTH.
REQ-014 SHALL have port OVERFLOW  output  1  sticky flag: a write was rejected while full.
REQ-015 SHALL have port DROP_CNT  output  8  saturating count of rejected writes.

Function
REQ-016 COUNT SHALL be (W_PTR - R_PTR) modulo 2^WIDTH, combinational from registered W_PTR and R_PTR.
REQ-017 FULL_FLAG SHALL be 1 exactly when W_PTR[WIDTH-1] != R_PTR[WIDTH-1] and W_PTR[WIDTH-2:0] == R_PTR[WIDTH-2:0] (COUNT == DEPTH).
REQ-018 Accepted write SHALL be INC & ~FULL_FLAG; WEN SHALL equal accepted write, combinational, same cycle.
REQ-019 On accepted write W_PTR SHALL increment by 1 at the next edge; memory captures data at ADDR_OUT on that same edge (zero-cycle latency from INC to write).
REQ-020 W_PTR SHALL wrap from 2^WIDTH-1 to 0; the MSB toggles each time ADDR_OUT wraps from DEPTH-1 to 0.
REQ-021 INC while FULL_FLAG=1: W_PTR unchanged, WEN=0, OVERFLOW set to 1 at next edge, DROP_CNT increments, saturating at 255.
REQ-022 Simultaneous read and write when full: write SHALL be rejected (FULL_FLAG uses R_PTR before the read updates it); FULL_FLAG deasserts the cycle after R_PTR advances.
REQ-023 Simultaneous read and write when not full: write accepted; COUNT unchanged after the edge.
REQ-024 CLR_OVF=1 SHALL clear OVERFLOW and DROP_CNT at next edge; if a rejected write occurs in the same cycle, clear takes priority.
REQ-025 ALMOST_FULL SHALL be COUNT >= AF_THRESH, combinational; FULL_FLAG=1 implies ALMOST_FULL=1.
REQ-026 COUNT > DEPTH SHALL never occur under legal R_PTR; block need not detect illegal R_PTR.

Reset
REQ-027 RST=0 SHALL immediately force W_PTR=0, OVERFLOW=0, DROP_CNT=0 regardless of CLK.
REQ-028 With R_PTR=0 during reset, outputs SHALL be ADDR_OUT=0, COUNT=0, FULL_FLAG=0, ALMOST_FULL=0, WEN=0 (WEN gated low while RST=0).
REQ-029 Reset asserted mid-burst SHALL abandon in-flight writes; first accepted write after deassertion uses ADDR_OUT=0.

Verification
REQ-030 WIDTH=8, reset, R_PTR=0, INC=1 for 128 cycles -> W_PTR=0x80, ADDR_OUT=0, COUNT=128, FULL_FLAG=1, WEN=0 from cycle 129.
REQ-031 From full, INC=1 for 3 more cycles -> W_PTR stays 0x80, OVERFLOW=1, DROP_CNT=3; then CLR_OVF pulse -> OVERFLOW=0, DROP_CNT=0.
REQ-032 From full, R_PTR steps 0->1 with INC=1 same cycle -> write rejected that cycle; next cycle FULL_FLAG=0, write accepted, W_PTR=0x81, FULL_FLAG=1 again.
REQ-033 W_PTR=0xFF, R_PTR=0x80, INC=1 -> W_PTR=0x00, ADDR_OUT=0, COUNT=0x80, FULL_FLAG=1 (wrap of pointer MSB).
REQ-034 AF_THRESH=124, fill to COUNT=123 -> ALMOST_FULL=0; one more write -> ALMOST_FULL=1, FULL_FLAG=0.
REQ-035 300 rejected writes while full -> DROP_CNT=255 saturated; RST pulse mid-write -> W_PTR=0, OVERFLOW=0, DROP_CNT=0 asynchronously.
